// File: rtl/kersram_r.sv
// Kernel SRAM read controller: sweeps eight 64-bit banks in lock-step and streams
// 512-bit words through a 2-entry skid FIFO. Optional macro: KERR_STALL_CNT_EN.
module kersram_r #(
    parameter int ADDR_CNT_BITS = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_ker_read,
    input  logic [ADDR_CNT_BITS-1:0] cfg_kerr_buflength,
    input  logic [7:0]               cfg_kerr_repeat,
    output logic                     cen_kersr_0,
    output logic                     cen_kersr_1,
    output logic                     cen_kersr_2,
    output logic                     cen_kersr_3,
    output logic                     cen_kersr_4,
    output logic                     cen_kersr_5,
    output logic                     cen_kersr_6,
    output logic                     cen_kersr_7,
    output logic                     wen_kersr_0,
    output logic                     wen_kersr_1,
    output logic                     wen_kersr_2,
    output logic                     wen_kersr_3,
    output logic                     wen_kersr_4,
    output logic                     wen_kersr_5,
    output logic                     wen_kersr_6,
    output logic                     wen_kersr_7,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_0,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_1,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_2,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_3,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_4,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_5,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_6,
    output logic [ADDR_CNT_BITS-1:0] addr_kersr_7,
    input  logic [63:0]              dout_kersr_0,
    input  logic [63:0]              dout_kersr_1,
    input  logic [63:0]              dout_kersr_2,
    input  logic [63:0]              dout_kersr_3,
    input  logic [63:0]              dout_kersr_4,
    input  logic [63:0]              dout_kersr_5,
    input  logic [63:0]              dout_kersr_6,
    input  logic [63:0]              dout_kersr_7,
    output logic [511:0]             ker_read_data,
    output logic                     ker_read_valid,
    input  logic                     ker_read_ready,
    output logic                     ker_read_busy,
    output logic                     ker_read_done,
    output logic [15:0]              ker_read_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_CNT_BITS-1:0] ONE_A  = {{(ADDR_CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_CNT_BITS-1:0] ZERO_A = {ADDR_CNT_BITS{1'b0}};

    state_t                   state_r, state_nxt_s;
    logic [ADDR_CNT_BITS-1:0] len_r, addr_cnt_r;
    logic [7:0]               pass_cnt_r;
    logic                     inflight_r;
    logic [511:0]             fifo0_r, fifo1_r;
    logic                     wr_ptr_r, rd_ptr_r;
    logic [1:0]               occ_r;
    logic                     pop_s, push_s, issue_s, wrap_s, last_issue_s, cen_s;
    logic [2:0]               load_s;
    logic [511:0]             rd_word_s;

    assign rd_word_s      = {dout_kersr_7, dout_kersr_6, dout_kersr_5, dout_kersr_4,
                             dout_kersr_3, dout_kersr_2, dout_kersr_1, dout_kersr_0};
    assign ker_read_valid = (occ_r != 2'd0);
    assign ker_read_data  = rd_ptr_r ? fifo1_r : fifo0_r;
    assign ker_read_busy  = (state_r != IDLE);
    assign ker_read_done  = (state_r == DONE);
    assign pop_s          = ker_read_valid & ker_read_ready;
    assign push_s         = inflight_r;

    // Issue decision: never let buffered plus in-flight words exceed the two FIFO slots.
    always_comb begin
        load_s       = {1'b0, occ_r} + {2'b00, inflight_r};
        issue_s      = 1'b0;
        wrap_s       = (addr_cnt_r == (len_r - ONE_A));
        last_issue_s = 1'b0;
        if ((state_r == RUN) && (load_s < (3'd2 + {2'b00, pop_s}))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (issue_s && wrap_s && (pass_cnt_r == 8'd0)) begin
            last_issue_s = 1'b1;
        end else begin
            last_issue_s = 1'b0;
        end
        cen_s = ~issue_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ker_read) begin
                    if (cfg_kerr_buflength == ZERO_A) state_nxt_s = DONE;
                    else                              state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_issue_s) state_nxt_s = DRAIN;
                else              state_nxt_s = RUN;
            end
            DRAIN: begin
                if (!inflight_r && (occ_r == 2'd0)) state_nxt_s = DONE;
                else                                state_nxt_s = DRAIN;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, config latch and address/pass counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            len_r      <= ZERO_A;
            addr_cnt_r <= ZERO_A;
            pass_cnt_r <= 8'd0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= issue_s;
            if ((state_r == IDLE) && start_ker_read) begin
                len_r      <= cfg_kerr_buflength;
                pass_cnt_r <= cfg_kerr_repeat;
                addr_cnt_r <= ZERO_A;
            end else if (issue_s) begin
                if (wrap_s) begin
                    addr_cnt_r <= ZERO_A;
                    if (pass_cnt_r != 8'd0) pass_cnt_r <= pass_cnt_r - 8'd1;
                end else begin
                    addr_cnt_r <= addr_cnt_r + ONE_A;
                end
            end
        end
    end

    // Two-entry skid FIFO; a concurrent push and pop leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo0_r  <= 512'd0;
            fifo1_r  <= 512'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                if (wr_ptr_r) fifo1_r <= rd_word_s;
                else          fifo0_r <= rd_word_s;
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

`ifdef KERR_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where the consumer holds off a valid word.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == IDLE) && start_ker_read) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r != IDLE) && ker_read_valid && !ker_read_ready &&
                     (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end
    assign ker_read_stall_cnt = stall_cnt_r;
`else
    assign ker_read_stall_cnt = 16'd0;
`endif

    assign cen_kersr_0  = cen_s;
    assign cen_kersr_1  = cen_s;
    assign cen_kersr_2  = cen_s;
    assign cen_kersr_3  = cen_s;
    assign cen_kersr_4  = cen_s;
    assign cen_kersr_5  = cen_s;
    assign cen_kersr_6  = cen_s;
    assign cen_kersr_7  = cen_s;
    assign wen_kersr_0  = 1'b1;
    assign wen_kersr_1  = 1'b1;
    assign wen_kersr_2  = 1'b1;
    assign wen_kersr_3  = 1'b1;
    assign wen_kersr_4  = 1'b1;
    assign wen_kersr_5  = 1'b1;
    assign wen_kersr_6  = 1'b1;
    assign wen_kersr_7  = 1'b1;
    assign addr_kersr_0 = issue_s ? addr_cnt_r : ZERO_A;
    assign addr_kersr_1 = issue_s ? addr_cnt_r : ZERO_A;
    assign addr_kersr_2 = issue_s ? addr_cnt_r : ZERO_A;
    assign addr_kersr_3 = issue_s ? addr_cnt_r : ZERO_A;
    assign addr_kersr_4 = issue_s ? addr_cnt_r : ZERO_A;
    assign addr_kersr_5 = issue_s ? addr_cnt_r : ZERO_A;
    assign addr_kersr_6 = issue_s ? addr_cnt_r : ZERO_A;
    assign addr_kersr_7 = issue_s ? addr_cnt_r : ZERO_A;

endmodule
